endian_lane_aligner: RTL and testbench

Parametrised byte-lane aligner and endianness converter between the execute stage and the data-memory bus.
- Stores: the low-order element of the request data is placed onto the correct bus byte lanes, optionally byte-reversed, and a byte-enable mask is generated.
- Loads: the element is extracted from the bus lanes, optionally byte-reversed, and zero- or sign-extended.
- One registered stage with a skid buffer under a valid/ready handshake, so it can sit between stalling pipeline stages.

---
 rtl/endian_lane_aligner.sv | 198 +++++++++++++++++++
 tb/tb_endian_lane_aligner.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endian_lane_aligner.sv
// Byte-lane aligner and endianness converter between execute and the data-memory bus, with
// one registered stage and a skid buffer. Define ENDIAN_LANE_ALIGNER_STATS_EN for counters.
module endian_lane_aligner #(
    parameter  int unsigned N_BYTES = 4,  // bus width in bytes (RV32 word by default)
    localparam int unsigned N_BITS  = N_BYTES * 8,
    localparam int unsigned OFF_W   = $clog2(N_BYTES)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_load,
    input  logic               in_big_endian,
    input  logic [1:0]         in_size,
    input  logic               in_sign_ext,
    input  logic [OFF_W-1:0]   in_offset,
    input  logic [N_BITS-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BITS-1:0]  out_data,
    output logic [N_BYTES-1:0] out_byte_en,
    output logic               out_misaligned
`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
    ,
    output logic [31:0]        stat_xfers,
    output logic [31:0]        stat_misaligned
`endif
);

    localparam logic [N_BITS-1:0]  BIT_ONE  = {{(N_BITS-1){1'b0}}, 1'b1};
    localparam logic [N_BYTES-1:0] LANE_ONE = {{(N_BYTES-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [N_BITS-1:0]  data;
        logic [N_BYTES-1:0] be;
        logic               mis;
    } result_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    function automatic logic [N_BITS-1:0] rev_bytes(input logic [N_BITS-1:0] d);
        logic [N_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            r[8*i +: 8] = d[8*(N_BYTES-1-i) +: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational align / extract
    // ------------------------------------------------------------------
    int unsigned        elem_bytes;
    int unsigned        off_bytes;
    int unsigned        rev_shift;
    int unsigned        off_shift;
    logic               misaligned;
    logic [N_BITS-1:0]  elem_mask;
    logic [N_BYTES-1:0] lane_mask;
    logic [N_BITS-1:0]  st_elem;
    logic [N_BITS-1:0]  ld_elem;
    logic [N_BITS-1:0]  ld_fill;
    logic               ld_sign;
    result_t            res;

    always_comb begin
        elem_bytes = 32'd1 << in_size;
        off_bytes  = 32'(in_offset);
        misaligned = (elem_bytes > N_BYTES) || ((off_bytes & (elem_bytes - 32'd1)) != 32'd0);
        // Shifting by the full width yields zero, so both masks become all-ones when E == N_BYTES.
        elem_mask  = (BIT_ONE << (8 * elem_bytes)) - BIT_ONE;
        lane_mask  = (LANE_ONE << elem_bytes) - LANE_ONE;
        rev_shift  = 8 * (N_BYTES - elem_bytes);
        off_shift  = 8 * off_bytes;

        st_elem = in_data & elem_mask;
        if (in_big_endian) begin
            st_elem = rev_bytes(st_elem) >> rev_shift;
        end

        ld_elem = (in_data >> off_shift) & elem_mask;
        if (in_big_endian) begin
            ld_elem = rev_bytes(ld_elem) >> rev_shift;
        end
        ld_sign = in_sign_ext && ((ld_elem & (BIT_ONE << (8 * elem_bytes - 32'd1))) != '0);
        ld_fill = ld_sign ? ~elem_mask : '0;

        res.mis = misaligned;
        if (misaligned) begin
            res.data = '0;
            res.be   = '0;
        end else if (in_is_load) begin
            res.data = ld_elem | ld_fill;
            res.be   = '0;
        end else begin
            res.data = st_elem << off_shift;
            res.be   = lane_mask << off_bytes;
        end
    end

    // ------------------------------------------------------------------
    // Main + skid register control
    // ------------------------------------------------------------------
    state_e  state_q, state_d;
    result_t m_q, s_q;
    logic    ready_q;
    logic    accept, drain;
    logic    m_load, m_from_s, s_load;

    assign accept = in_valid && ready_q;
    assign drain  = (state_q != StEmpty) && out_ready;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    m_load  = 1'b1;
                end
            end
            StOne: begin
                if (accept && !drain) begin
                    state_d = StTwo;
                    s_load  = 1'b1;
                end else if (accept && drain) begin
                    m_load = 1'b1;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (drain) begin
                    state_d  = StOne;
                    m_from_s = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // ready is a register so out_ready never reaches in_ready combinationally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StEmpty;
            ready_q <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StTwo);
            if (m_load) begin
                m_q <= res;
            end else if (m_from_s) begin
                m_q <= s_q;
            end
            if (s_load) begin
                s_q <= res;
            end
        end
    end

    assign in_ready       = ready_q;
    assign out_valid      = (state_q != StEmpty);
    assign out_data       = m_q.data;
    assign out_byte_en    = m_q.be;
    assign out_misaligned = m_q.mis;

`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
    logic [31:0] xfer_cnt_q;
    logic [31:0] mis_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xfer_cnt_q <= '0;
            mis_cnt_q  <= '0;
        end else if (drain) begin
            if (xfer_cnt_q != 32'hFFFF_FFFF) begin
                xfer_cnt_q <= xfer_cnt_q + 32'd1;
            end
            if (m_q.mis && (mis_cnt_q != 32'hFFFF_FFFF)) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign stat_xfers      = xfer_cnt_q;
    assign stat_misaligned = mis_cnt_q;
`endif

endmodule

// File: tb/tb_endian_lane_aligner.sv
// Scoreboard bench for endian_lane_aligner: 4-byte and 8-byte instances, directed vectors.
module tb_endian_lane_aligner;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // 4-byte instance
    logic        in_valid, in_ready, in_is_load, in_big_endian, in_sign_ext;
    logic [1:0]  in_size, in_offset;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_misaligned;
    logic [31:0] out_data;
    logic [3:0]  out_byte_en;

    // 8-byte instance
    logic        w_in_valid, w_in_ready, w_in_is_load, w_in_big_endian, w_in_sign_ext;
    logic [1:0]  w_in_size;
    logic [2:0]  w_in_offset;
    logic [63:0] w_in_data;
    logic        w_out_valid, w_out_ready, w_out_misaligned;
    logic [63:0] w_out_data;
    logic [7:0]  w_out_byte_en;

`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
    logic [31:0] stat_xfers, stat_misaligned, w_stat_xfers, w_stat_misaligned;
`endif

    endian_lane_aligner #(.N_BYTES(4)) dut4 (
        .CLK            (CLK),
        .RST            (RST),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_load     (in_is_load),
        .in_big_endian  (in_big_endian),
        .in_size        (in_size),
        .in_sign_ext    (in_sign_ext),
        .in_offset      (in_offset),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_byte_en    (out_byte_en),
        .out_misaligned (out_misaligned)
`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
        ,
        .stat_xfers     (stat_xfers),
        .stat_misaligned(stat_misaligned)
`endif
    );

    endian_lane_aligner #(.N_BYTES(8)) dut8 (
        .CLK            (CLK),
        .RST            (RST),
        .in_valid       (w_in_valid),
        .in_ready       (w_in_ready),
        .in_is_load     (w_in_is_load),
        .in_big_endian  (w_in_big_endian),
        .in_size        (w_in_size),
        .in_sign_ext    (w_in_sign_ext),
        .in_offset      (w_in_offset),
        .in_data        (w_in_data),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_data       (w_out_data),
        .out_byte_en    (w_out_byte_en),
        .out_misaligned (w_out_misaligned)
`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
        ,
        .stat_xfers     (w_stat_xfers),
        .stat_misaligned(w_stat_misaligned)
`endif
    );

    typedef struct packed {
        int          id;
        logic [63:0] data;
        logic [7:0]  be;
        logic        mis;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    int   n_xfer = 0;
    int   n_mis  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitors: pop and compare whenever a handshake is about to complete.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            n_xfer++;
            if (out_misaligned) n_mis++;
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out4: got data %h with empty scoreboard", out_data);
            end else begin
                e4 = q4.pop_front();
                check($sformatf("data4[v%0d]", e4.id), 64'(out_data), e4.data);
                check($sformatf("be4[v%0d]", e4.id), 64'(out_byte_en), 64'(e4.be));
                check($sformatf("mis4[v%0d]", e4.id), 64'(out_misaligned), 64'(e4.mis));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && w_out_valid && w_out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got data %h with empty scoreboard", w_out_data);
            end else begin
                e8 = q8.pop_front();
                check($sformatf("data8[v%0d]", e8.id), w_out_data, e8.data);
                check($sformatf("be8[v%0d]", e8.id), 64'(w_out_byte_en), 64'(e8.be));
                check($sformatf("mis8[v%0d]", e8.id), 64'(w_out_misaligned), 64'(e8.mis));
            end
        end
    end

    task automatic send4(input logic ld, input logic big, input logic sx, input logic [1:0] sz,
                         input logic [1:0] off, input logic [31:0] d, input logic [31:0] ed,
                         input logic [3:0] ebe, input logic emis);
        int   t;
        exp_t e;
        vec_id++;
        in_valid = 1'b1; in_is_load = ld; in_big_endian = big; in_sign_ext = sx;
        in_size = sz; in_offset = off; in_data = d;
        t = 0;
        @(negedge CLK);
        while (!in_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout4[v%0d]: in_ready 0 after 200 cycles, required 1", vec_id);
        end else begin
            e.id = vec_id; e.data = 64'(ed); e.be = 8'(ebe); e.mis = emis;
            q4.push_back(e);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic ld, input logic big, input logic sx, input logic [1:0] sz,
                         input logic [2:0] off, input logic [63:0] d, input logic [63:0] ed,
                         input logic [7:0] ebe, input logic emis);
        int   t;
        exp_t e;
        vec_id++;
        w_in_valid = 1'b1; w_in_is_load = ld; w_in_big_endian = big; w_in_sign_ext = sx;
        w_in_size = sz; w_in_offset = off; w_in_data = d;
        t = 0;
        @(negedge CLK);
        while (!w_in_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!w_in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout8[v%0d]: in_ready 0 after 200 cycles, required 1", vec_id);
        end else begin
            e.id = vec_id; e.data = ed; e.be = ebe; e.mis = emis;
            q8.push_back(e);
        end
        @(posedge CLK);
        #1;
        w_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q4.size() != 0 || q8.size() != 0) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results pending, required 0", q4.size(),
                     q8.size());
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0; in_is_load = 1'b0; in_big_endian = 1'b0; in_sign_ext = 1'b0;
        in_size = 2'd0; in_offset = 2'd0; in_data = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_is_load = 1'b0; w_in_big_endian = 1'b0; w_in_sign_ext = 1'b0;
        w_in_size = 2'd0; w_in_offset = 3'd0; w_in_data = '0; w_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_be", 64'(out_byte_en), 64'd0);
        check("rst_out_mis", 64'(out_misaligned), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge CLK);
        #1;

        // Stores, loads, misaligned cases (4-byte bus)
        send4(0, 0, 0, 2'd0, 2'd3, 32'h0000_00AB, 32'hAB00_0000, 4'b1000, 0);
        send4(0, 1, 0, 2'd1, 2'd2, 32'h0000_1234, 32'h3412_0000, 4'b1100, 0);
        send4(1, 0, 1, 2'd1, 2'd2, 32'h8001_FFFF, 32'hFFFF_8001, 4'b0000, 0);
        send4(1, 0, 0, 2'd1, 2'd2, 32'h8001_FFFF, 32'h0000_8001, 4'b0000, 0);
        send4(1, 1, 0, 2'd1, 2'd2, 32'h8001_FFFF, 32'h0000_0180, 4'b0000, 0);
        send4(0, 0, 0, 2'd2, 2'd1, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 1);
        send4(1, 0, 1, 2'd2, 2'd1, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 1);
        send4(1, 0, 0, 2'd3, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 1);
        send4(0, 0, 0, 2'd2, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 0);
        send4(0, 1, 0, 2'd2, 2'd0, 32'hDEAD_BEEF, 32'hEFBE_ADDE, 4'b1111, 0);
        send4(1, 0, 1, 2'd0, 2'd1, 32'h0000_8000, 32'hFFFF_FF80, 4'b0000, 0);
        send4(1, 1, 0, 2'd0, 2'd1, 32'h0000_8000, 32'h0000_0080, 4'b0000, 0);
        send4(1, 0, 1, 2'd2, 2'd0, 32'h8000_0001, 32'h8000_0001, 4'b0000, 0);
        send4(1, 1, 1, 2'd2, 2'd0, 32'h1122_3344, 32'h4433_2211, 4'b0000, 0);
        send4(0, 0, 0, 2'd0, 2'd0, 32'h1234_5678, 32'h0000_0078, 4'b0001, 0);
        send4(0, 1, 0, 2'd1, 2'd1, 32'h0000_ABCD, 32'h0000_0000, 4'b0000, 1);
        send4(1, 1, 1, 2'd1, 2'd0, 32'h0000_80FF, 32'hFFFF_FF80, 4'b0000, 0);
        wait_drain();

        // 8-byte bus: dword and word cases
        send8(1, 1, 0, 2'd3, 3'd0, 64'h0123_4567_89AB_CDEF, 64'hEFCD_AB89_6745_2301, 8'h00, 0);
        send8(0, 0, 0, 2'd3, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
        send8(0, 1, 0, 2'd2, 3'd4, 64'h1111_1111_AABB_CCDD, 64'hDDCC_BBAA_0000_0000, 8'hF0, 0);
        send8(1, 0, 1, 2'd2, 3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 8'h00, 0);
        send8(0, 0, 0, 2'd2, 3'd6, 64'h1234_5678_9ABC_DEF0, 64'h0, 8'h00, 1);
        send8(1, 0, 0, 2'd3, 3'd4, 64'h1234_5678_9ABC_DEF0, 64'h0, 8'h00, 1);
        wait_drain();

        // Back-pressure: two accepts fill main+skid, outputs hold, then drain in order
        out_ready = 1'b0;
        send4(0, 0, 0, 2'd0, 2'd3, 32'h0000_00AB, 32'hAB00_0000, 4'b1000, 0);
        send4(0, 1, 0, 2'd1, 2'd0, 32'h0000_BEEF, 32'h0000_EFBE, 4'b0011, 0);
        @(negedge CLK);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        fork
            begin
                send4(1, 0, 0, 2'd0, 2'd2, 32'h0055_0000, 32'h0000_0055, 4'b0000, 0);
                send4(0, 0, 0, 2'd1, 2'd3, 32'h0000_1234, 32'h0000_0000, 4'b0000, 1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge CLK);
                    check("bp_hold_valid", 64'(out_valid), 64'd1);
                    check("bp_hold_data", 64'(out_data), 64'h0000_0000_AB00_0000);
                    check("bp_hold_be", 64'(out_byte_en), 64'h8);
                    check("bp_hold_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
        check("stat_xfers", 64'(stat_xfers), 64'(n_xfer));
        check("stat_misaligned", 64'(stat_misaligned), 64'(n_mis));
`endif

        // Reset while full: in-flight results vanish
        out_ready = 1'b0;
        send4(0, 0, 0, 2'd2, 2'd0, 32'h0102_0304, 32'h0102_0304, 4'b1111, 0);
        send4(0, 0, 0, 2'd2, 2'd0, 32'h0506_0708, 32'h0506_0708, 4'b1111, 0);
        @(negedge CLK);
        check("full_in_ready", 64'(in_ready), 64'd0);
        RST = 1'b1;
        #1;
        q4.delete();
        n_xfer = 0;
        n_mis  = 0;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
`ifdef ENDIAN_LANE_ALIGNER_STATS_EN
        check("arst_stat_xfers", 64'(stat_xfers), 64'd0);
        check("arst_stat_mis", 64'(stat_misaligned), 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_out_be", 64'(out_byte_en), 64'd0);
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        send4(1, 0, 0, 2'd2, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b0000, 0);
        wait_drain();
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
